// File: rtl/miner_job_sched.sv
// miner_job_sched: latches a mining job, sequences both hashers over a nonce range,
// and queues golden nonces in a FIFO metered out to the transmit path.
module miner_job_sched #(
   parameter int LOOP_LOG2 = 5,
   parameter int FIFO_AW = 2,
   parameter int HOLDOFF = 16
) (
   input  logic         hash_clk,
   input  logic         rst_n,
   input  logic         job_valid,
   input  logic [383:0] job_data,
   input  logic [31:0]  job_nonce_start,
   input  logic [31:0]  job_nonce_end,
   input  logic [31:0]  hash2_top,
   input  logic         tx_busy,
   output logic [255:0] state,
   output logic [511:0] data,
   output logic [5:0]   cnt,
   output logic         feedback,
   output logic         send,
   output logic [31:0]  nonce_word,
   output logic         idle,
   output logic         done,
   output logic         overflow
);
   localparam int LOOP = 1 << LOOP_LOG2;
   localparam int OFFSET = (1 << (7 - LOOP_LOG2)) + 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int HW = $clog2(HOLDOFF);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} fsm_t;
   fsm_t fsm;
   logic loaded;
   logic [95:0] tail;
   logic [31:0] nonce_ctr, nonce_end, rpt;
   logic [5:0] cnt_next, round_idx, flush_cnt;
   logic wrap, is_golden, feedback_d1, push, pop, wr_en, full;
   logic [31:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0] count;
   logic [HW-1:0] holdoff;
   logic unused_bits;
   assign unused_bits = ^job_data[127:96];
   assign data = {loaded ? {32'h00000280, 320'h0, 32'h80000000} : 384'h0, nonce_ctr, tail};
   assign cnt_next = (cnt + 6'd1) & 6'(LOOP - 1);
   assign wrap = cnt_next == 6'd0;
   assign full = count[FIFO_AW];
   assign pop = count != '0 && !tx_busy && holdoff == '0;
   // detections before OFFSET rounds belong to the hasher pipeline of a previous load
   assign push = is_golden && round_idx >= 6'(OFFSET);
   assign wr_en = push && (!full || pop);
   always_ff @(posedge hash_clk) begin
      if (!rst_n) begin
         fsm <= IDLE;
         loaded <= 1'b0;
         state <= '0;
         tail <= '0;
         nonce_ctr <= '0;
         nonce_end <= '0;
         rpt <= '0;
         cnt <= '0;
         feedback <= 1'b0;
         round_idx <= '0;
         flush_cnt <= '0;
         idle <= 1'b1;
         done <= 1'b0;
         is_golden <= 1'b0;
         feedback_d1 <= 1'b0;
      end else begin
         done <= 1'b0;
         feedback_d1 <= feedback;
         is_golden <= fsm != IDLE && hash2_top == 32'h0 && !feedback_d1;
         if (job_valid) begin
            fsm <= RUN;
            loaded <= 1'b1;
            state <= job_data[383:128];
            tail <= job_data[95:0];
            nonce_ctr <= job_nonce_start;
            nonce_end <= job_nonce_end;
            rpt <= job_nonce_start;
            cnt <= '0;
            feedback <= 1'b0;
            round_idx <= '0;
            flush_cnt <= '0;
            idle <= 1'b0;
         end else if (fsm != IDLE) begin
            cnt <= cnt_next;
            feedback <= !wrap;
            if (wrap) begin
               rpt <= rpt + 32'd1;
               if (round_idx < 6'(OFFSET)) round_idx <= round_idx + 6'd1;
               if (fsm == RUN) begin
                  if (nonce_ctr == nonce_end) fsm <= FLUSH;
                  else nonce_ctr <= nonce_ctr + 32'd1;
               end else if (flush_cnt == 6'(OFFSET - 1)) begin
                  fsm <= IDLE;
                  idle <= 1'b1;
                  done <= 1'b1;
               end else flush_cnt <= flush_cnt + 6'd1;
            end
         end
      end
   end
   always_ff @(posedge hash_clk) begin
      if (wr_en) mem[wr_ptr] <= rpt - 32'(OFFSET);
   end
   always_ff @(posedge hash_clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         holdoff <= '0;
         send <= 1'b0;
         nonce_word <= '0;
         overflow <= 1'b0;
      end else begin
         send <= pop;
         if (pop) begin
            nonce_word <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
            holdoff <= HW'(HOLDOFF - 1);
         end else if (holdoff != '0) holdoff <= holdoff - 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (wr_en != pop) count <= wr_en ? count + 1'b1 : count - 1'b1;
         if (job_valid) overflow <= 1'b0;
         else if (push && full && !pop) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_miner_job_sched.sv
// tb_miner_job_sched: scenario tasks against an arithmetic model of rounds, reports and sends.
module tb_miner_job_sched;
   logic hash_clk = 1'b0, rst_n = 1'b0, job_valid = 1'b0, tx_busy = 1'b0;
   logic [383:0] job_data = '0;
   logic [31:0] job_nonce_start = '0, job_nonce_end = '0, hash2_top = 32'hFFFF_FFFF;
   logic [255:0] state;
   logic [511:0] data;
   logic [5:0] cnt;
   logic feedback, send, idle, done, overflow;
   logic [31:0] nonce_word;
   localparam logic [383:0] PAD = {32'h00000280, 320'h0, 32'h80000000};
   int vectors = 0, miscompares = 0, jn = 0, cyc = 0;
   logic [255:0] exp_mid;
   logic [95:0] exp_tail;
   logic busy_edge;
   logic [31:0] s_val[$];
   int s_cyc[$];
   logic s_busy[$];

   miner_job_sched dut (
      .hash_clk(hash_clk), .rst_n(rst_n), .job_valid(job_valid), .job_data(job_data),
      .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end), .hash2_top(hash2_top),
      .tx_busy(tx_busy), .state(state), .data(data), .cnt(cnt), .feedback(feedback),
      .send(send), .nonce_word(nonce_word), .idle(idle), .done(done), .overflow(overflow)
   );

   always #5 hash_clk = ~hash_clk;

   always @(posedge hash_clk) begin
      cyc++;
      busy_edge = tx_busy;
      #2;
      if (send) begin
         s_val.push_back(nonce_word);
         s_cyc.push_back(cyc);
         s_busy.push_back(busy_edge);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge hash_clk);
      jn++;
   endtask

   task automatic goto(input int n);
      while (jn < n) tick();
   endtask

   task automatic load_job(input logic [31:0] s, input logic [31:0] e);
      exp_mid = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_tail = {$urandom, $urandom, $urandom};
      job_data = {exp_mid, $urandom, exp_tail};
      job_nonce_start = s;
      job_nonce_end = e;
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      jn = 0;
   endtask

   task automatic inject_round(input int k);
      goto(32 * k + 1);
      hash2_top = 32'h0;
      tick();
      hash2_top = $urandom | 32'h1;
   endtask

   task automatic clear_sends();
      s_val.delete();
      s_cyc.delete();
      s_busy.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      vectors++;
      if (state !== '0) begin miscompares++; $display("FAIL reset_state got %h want 0", state); end
      vectors++;
      if (data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", data); end
      vectors++;
      if ({cnt, feedback, send, nonce_word, idle, done, overflow} !== {6'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_ctrl got cnt=%0d fb=%b send=%b nw=%h idle=%b done=%b ovf=%b want 0,0,0,0,1,0,0",
                  cnt, feedback, send, nonce_word, idle, done, overflow);
      end
      rst_n = 1'b1;
      repeat (5) tick();
      vectors++;
      if (idle !== 1'b1 || cnt !== 6'd0 || send !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset got idle=%b cnt=%0d send=%b want 1,0,0", idle, cnt, send);
      end
   endtask

   task automatic test_sequencing();
      load_job(32'h100, 32'hFFFF);
      vectors++;
      if (state !== exp_mid || data[95:0] !== exp_tail || data[511:128] !== PAD || idle !== 1'b0) begin
         miscompares++;
         $display("FAIL seq_job_latch got mid_ok=%b tail_ok=%b pad_ok=%b idle=%b want 1,1,1,0",
                  state === exp_mid, data[95:0] === exp_tail, data[511:128] === PAD, idle);
      end
      while (jn <= 40) begin
         vectors++;
         if (cnt !== 6'(jn % 32) || feedback !== (jn % 32 != 0)) begin
            miscompares++;
            $display("FAIL seq_cnt n=%0d got cnt=%0d fb=%b want %0d,%b", jn, cnt, feedback, jn % 32, jn % 32 != 0);
         end
         vectors++;
         if (data[127:96] !== 32'h100 + 32'(jn / 32)) begin
            miscompares++;
            $display("FAIL seq_nonce n=%0d got %h want %h", jn, data[127:96], 32'h100 + 32'(jn / 32));
         end
         tick();
      end
   endtask

   task automatic test_golden();
      load_job(32'h103, 32'hFFFF);
      inject_round(3);
      repeat (5) begin
         vectors++;
         if (send !== 1'b0) begin miscompares++; $display("FAIL golden_stale got send=%b want 0", send); end
         tick();
      end
      inject_round(7);
      for (int i = 1; i <= 4; i++) begin
         vectors++;
         if (send !== (i == 3)) begin
            miscompares++;
            $display("FAIL golden_latency cycle+%0d got send=%b want %b", i, send, i == 3);
         end
         if (i == 3) begin
            vectors++;
            if (nonce_word !== 32'h105) begin
               miscompares++;
               $display("FAIL golden_nonce got %h want 00000105", nonce_word);
            end
         end
         tick();
      end
   endtask

   task automatic test_overflow();
      logic [31:0] s;
      s = $urandom & 32'h7FFF_FFFF;
      tx_busy = 1'b1;
      clear_sends();
      load_job(s, s + 32'd100);
      for (int k = 5; k <= 9; k++) inject_round(k);
      goto(9 * 32 + 5);
      vectors++;
      if (overflow !== 1'b1 || s_val.size() != 0) begin
         miscompares++;
         $display("FAIL ovf_flag got ovf=%b sends=%0d want 1,0", overflow, s_val.size());
      end
      tx_busy = 1'b0;
      repeat (100) tick();
      vectors++;
      if (s_val.size() != 4) begin
         miscompares++;
         $display("FAIL ovf_count got %0d sends want 4", s_val.size());
      end
      for (int i = 0; i < s_val.size() && i < 4; i++) begin
         vectors++;
         if (s_val[i] !== s + 32'(i)) begin
            miscompares++;
            $display("FAIL ovf_order idx=%0d got %h want %h", i, s_val[i], s + 32'(i));
         end
         if (i > 0) begin
            vectors++;
            if (s_cyc[i] - s_cyc[i-1] < 16) begin
               miscompares++;
               $display("FAIL ovf_spacing idx=%0d got gap %0d want >=16", i, s_cyc[i] - s_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_exhaust();
      int done_n;
      done_n = (3 + 5) * 32;
      tx_busy = 1'b0;
      load_job(32'd10, 32'd12);
      while (jn <= done_n + 4) begin
         vectors++;
         if (done !== (jn == done_n) || idle !== (jn >= done_n)) begin
            miscompares++;
            $display("FAIL exh_done n=%0d got done=%b idle=%b want %b,%b", jn, done, idle, jn == done_n, jn >= done_n);
         end
         vectors++;
         if (data[127:96] !== 32'd10 + 32'(jn / 32 < 2 ? jn / 32 : 2)) begin
            miscompares++;
            $display("FAIL exh_nonce n=%0d got %0d want %0d", jn, data[127:96], 10 + (jn / 32 < 2 ? jn / 32 : 2));
         end
         vectors++;
         if (send !== (jn == 7 * 32 + 4) || (send && nonce_word !== 32'd12)) begin
            miscompares++;
            $display("FAIL exh_flush_golden n=%0d got send=%b nw=%0d want %b,12", jn, send, nonce_word, jn == 7 * 32 + 4);
         end
         hash2_top = (jn == 7 * 32 + 1) ? 32'h0 : ($urandom | 32'h1);
         tick();
      end
      hash2_top = 32'hFFFF_FFFF;
      vectors++;
      if (cnt !== 6'd0 || feedback !== 1'b0) begin
         miscompares++;
         $display("FAIL exh_idle_cnt got cnt=%0d fb=%b want 0,0", cnt, feedback);
      end
   endtask

   task automatic test_abort();
      logic [31:0] s, t;
      s = $urandom & 32'h7FFF_FFFF;
      t = $urandom & 32'h7FFF_FFFF;
      tx_busy = 1'b1;
      clear_sends();
      load_job(s, s + 32'd100);
      for (int k = 5; k <= 9; k++) inject_round(k);
      goto(300);
      vectors++;
      if (overflow !== 1'b1) begin miscompares++; $display("FAIL abort_pre_ovf got %b want 1", overflow); end
      load_job(t, t + 32'd50);
      vectors++;
      if (overflow !== 1'b0 || cnt !== 6'd0 || feedback !== 1'b0 || data[127:96] !== t || state !== exp_mid) begin
         miscompares++;
         $display("FAIL abort_load got ovf=%b cnt=%0d fb=%b nonce=%h mid_ok=%b want 0,0,0,%h,1",
                  overflow, cnt, feedback, data[127:96], state === exp_mid, t);
      end
      tick();
      vectors++;
      if (cnt !== 6'd1 || feedback !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_step got cnt=%0d fb=%b want 1,1", cnt, feedback);
      end
      inject_round(2);
      goto(100);
      tx_busy = 1'b0;
      repeat (100) tick();
      vectors++;
      if (s_val.size() != 4 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_sends got %0d sends ovf=%b want 4,0", s_val.size(), overflow);
      end
      for (int i = 0; i < s_val.size() && i < 4; i++) begin
         vectors++;
         if (s_val[i] !== s + 32'(i)) begin
            miscompares++;
            $display("FAIL abort_order idx=%0d got %h want %h", i, s_val[i], s + 32'(i));
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         logic [31:0] s;
         int len, t;
         bit inj[16];
         logic [31:0] exp_q[$];
         s = $urandom & 32'h7FFF_FFFF;
         len = $urandom_range(1, 7);
         t = (len + 5) * 32;
         for (int k = 0; k < len + 5; k++) begin
            inj[k] = ($urandom_range(0, 2) == 0);
            if (inj[k] && k >= 5) exp_q.push_back(s + 32'(k - 5));
         end
         clear_sends();
         load_job(s, s + 32'(len - 1));
         while (jn <= t + 1) begin
            vectors++;
            if (done !== (jn == t) || idle !== (jn >= t)) begin
               miscompares++;
               $display("FAIL rnd_done it=%0d n=%0d got done=%b idle=%b want %b,%b", it, jn, done, idle, jn == t, jn >= t);
            end
            vectors++;
            if (data[127:96] !== s + 32'(jn / 32 < len ? jn / 32 : len - 1)) begin
               miscompares++;
               $display("FAIL rnd_nonce it=%0d n=%0d got %h want %h", it, jn, data[127:96], s + 32'(jn / 32 < len ? jn / 32 : len - 1));
            end
            hash2_top = (jn % 32 == 1 && jn / 32 < len + 5 && inj[jn / 32]) ? 32'h0 : ($urandom | 32'h1);
            tx_busy = ($urandom_range(0, 3) == 0);
            tick();
         end
         hash2_top = 32'hFFFF_FFFF;
         tx_busy = 1'b0;
         repeat (100) tick();
         vectors++;
         if (s_val.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rnd_count it=%0d got %0d sends want %0d", it, s_val.size(), exp_q.size());
         end
         for (int i = 0; i < s_val.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (s_val[i] !== exp_q[i] || s_busy[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL rnd_send it=%0d idx=%0d got %h busy=%b want %h busy=0", it, i, s_val[i], s_busy[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      tx_busy = 1'b1;
      load_job($urandom & 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      inject_round(5);
      inject_round(6);
      goto(250);
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      vectors++;
      if (state !== '0 || data !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_datapath got state_zero=%b data_zero=%b want 1,1", state === '0, data === '0);
      end
      vectors++;
      if ({cnt, feedback, send, nonce_word, idle, done, overflow} !== {6'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_mid_ctrl got cnt=%0d fb=%b send=%b nw=%h idle=%b done=%b ovf=%b want 0,0,0,0,1,0,0",
                  cnt, feedback, send, nonce_word, idle, done, overflow);
      end
      tx_busy = 1'b0;
      repeat (100) begin
         tick();
         vectors++;
         if (send !== 1'b0 || idle !== 1'b1 || cnt !== 6'd0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet got send=%b idle=%b cnt=%0d want 0,1,0", send, idle, cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequencing();
      test_golden();
      test_overflow();
      test_exhaust();
      test_abort();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
